// File: rtl/multi_cycle_ctrl_pkg.sv
// Encodings shared by the multi-cycle CPU control unit: phase states, opcodes, ALUOp, mux selects.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a. CTRL_HALT_EN selects whether the halt opcode parks the machine in HALT.
package ctrl_pkg;

    // Phase encodings; ID and WB values are relied upon by the register file.
    typedef enum logic [2:0] {
        ST_IF   = 3'b000,
        ST_ID   = 3'b001,
        ST_EXA  = 3'b110,
        ST_EXB  = 3'b101,
        ST_EXL  = 3'b010,
        ST_MEM  = 3'b100,
        ST_WB   = 3'b011,
        ST_HALT = 3'b111
    } ctrlStateT;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_LTU  = 3'b101;
    localparam logic [2:0] ALU_LTS  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] DST_RA   = 2'b00;
    localparam logic [1:0] DST_RT   = 2'b01;
    localparam logic [1:0] DST_RD   = 2'b10;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

`ifdef CTRL_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    function automatic logic isJump(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
    endfunction

    function automatic logic isBranch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
    endfunction

    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational decode of (phase, opcode, ALU flags) into every datapath control line.
// Latency: zero cycles, purely combinational.
// Backpressure: none. Halt behaviour follows CTRL_HALT_EN through ctrl_pkg::HALT_EN.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  ctrlStateT   state,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic        mRD,
    output logic        mWR,
    output logic        RegWre,
    output logic [1:0]  RegDst,
    output logic        WrRegDSrc,
    output logic        DBDataSrc,
    output logic [1:0]  PCSrc
);

    logic       aluWrite;
    logic       srcA;
    logic       srcB;
    logic       extSign;
    logic [2:0] aluSel;
    logic [1:0] dstSel;
    logic       branchTaken;

    // Phase-independent opcode decode: datapath steering for the latched instruction.
    always_comb begin
        aluWrite = 1'b0;
        srcA     = 1'b0;
        srcB     = 1'b0;
        extSign  = 1'b0;
        aluSel   = ALU_ADD;
        dstSel   = DST_RA;
        case (opcode)
            OP_ADD:   begin aluWrite = 1'b1; dstSel = DST_RD; end
            OP_SUB:   begin aluWrite = 1'b1; dstSel = DST_RD; aluSel = ALU_SUB; end
            OP_ADDIU: begin aluWrite = 1'b1; dstSel = DST_RT; srcB = 1'b1; extSign = 1'b1; end
            OP_AND:   begin aluWrite = 1'b1; dstSel = DST_RD; aluSel = ALU_AND; end
            OP_ANDI:  begin aluWrite = 1'b1; dstSel = DST_RT; srcB = 1'b1; aluSel = ALU_AND; end
            OP_ORI:   begin aluWrite = 1'b1; dstSel = DST_RT; srcB = 1'b1; aluSel = ALU_OR; end
            OP_XORI:  begin aluWrite = 1'b1; dstSel = DST_RT; srcB = 1'b1; aluSel = ALU_XOR; end
            OP_SLL:   begin aluWrite = 1'b1; dstSel = DST_RD; srcA = 1'b1; aluSel = ALU_SLL; end
            OP_SLT:   begin aluWrite = 1'b1; dstSel = DST_RD; aluSel = ALU_LTS; end
            OP_SLTI:  begin aluWrite = 1'b1; dstSel = DST_RT; srcB = 1'b1; extSign = 1'b1; aluSel = ALU_LTS; end
            OP_SW:    begin srcB = 1'b1; extSign = 1'b1; end
            OP_LW:    begin dstSel = DST_RT; srcB = 1'b1; extSign = 1'b1; end
            // Branches compare by subtraction: zero for beq/bne, sign for bltz.
            OP_BEQ, OP_BNE, OP_BLTZ: begin extSign = 1'b1; aluSel = ALU_SUB; end
            default: ;
        endcase
    end

    // Flags matter only for the branch decision; they are qualified by EXB below.
    always_comb begin
        branchTaken = ((opcode == OP_BEQ)  &&  zero) ||
                      ((opcode == OP_BNE)  && !zero) ||
                      ((opcode == OP_BLTZ) &&  sign);
    end

    // Phase-qualified outputs: enables pulse only in their owning phase, HALT drives all zeros.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = ALU_ADD;
        mRD       = 1'b0;
        mWR       = 1'b0;
        RegWre    = 1'b0;
        RegDst    = DST_RA;
        WrRegDSrc = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = PC_NEXT;
        if (state != ST_HALT) begin
            ALUSrcA   = srcA;
            ALUSrcB   = srcB;
            ExtSel    = extSign;
            ALUOp     = aluSel;
            RegDst    = dstSel;
            WrRegDSrc = (opcode != OP_JAL);
            DBDataSrc = (opcode == OP_LW);
            if (opcode == OP_JR) begin
                PCSrc = PC_REG;
            end else if ((opcode == OP_J) || (opcode == OP_JAL)) begin
                PCSrc = PC_JUMP;
            end
        end
        case (state)
            ST_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
            end
            ST_ID: begin
                // Jumps retire in ID; halt does too when it is only a no-op.
                PCWre  = isJump(opcode) || (!HALT_EN && (opcode == OP_HALT));
                RegWre = (opcode == OP_JAL);
            end
            ST_EXB: begin
                PCWre = 1'b1;
                if (branchTaken) begin
                    PCSrc = PC_BRANCH;
                end
            end
            ST_MEM: begin
                mRD   = (opcode == OP_LW);
                mWR   = (opcode == OP_SW);
                PCWre = (opcode == OP_SW);
            end
            ST_WB: begin
                PCWre  = 1'b1;
                RegWre = aluWrite || (opcode == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: instruction-phase FSM plus combinational control decode.
// Latency: outputs combinational from current state; state advances every CLK posedge.
// Backpressure: none; RST low forces state IF and every output to 0. CTRL_HALT_EN enables HALT.
module multi_cycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        sign,
    output logic [2:0]  state,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InsMemRW,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        ExtSel,
    output logic [2:0]  ALUOp,
    output logic        mRD,
    output logic        mWR,
    output logic        RegWre,
    output logic [1:0]  RegDst,
    output logic        WrRegDSrc,
    output logic        DBDataSrc,
    output logic [1:0]  PCSrc
);

    localparam ctrlStateT HALT_DEST = HALT_EN ? ST_HALT : ST_IF;

    ctrlStateT  stateQ;
    ctrlStateT  stateNext;

    logic       dPCWre;
    logic       dIRWre;
    logic       dInsMemRW;
    logic       dALUSrcA;
    logic       dALUSrcB;
    logic       dExtSel;
    logic [2:0] dALUOp;
    logic       dmRD;
    logic       dmWR;
    logic       dRegWre;
    logic [1:0] dRegDst;
    logic       dWrRegDSrc;
    logic       dDBDataSrc;
    logic [1:0] dPCSrc;

    // Phase register; reset drops straight back to IF and abandons the instruction.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stateQ <= ST_IF;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Next-phase selection from the current phase and the latched opcode.
    always_comb begin
        stateNext = stateQ;
        case (stateQ)
            ST_IF:  stateNext = ST_ID;
            ST_ID: begin
                if (isJump(opcode)) begin
                    stateNext = ST_IF;
                end else if (isBranch(opcode)) begin
                    stateNext = ST_EXB;
                end else if (isMemOp(opcode)) begin
                    stateNext = ST_EXL;
                end else if (opcode == OP_HALT) begin
                    stateNext = HALT_DEST;
                end else begin
                    stateNext = ST_EXA;
                end
            end
            ST_EXA:  stateNext = ST_WB;
            ST_EXB:  stateNext = ST_IF;
            ST_EXL:  stateNext = ST_MEM;
            ST_MEM:  stateNext = (opcode == OP_LW) ? ST_WB : ST_IF;
            ST_WB:   stateNext = ST_IF;
            ST_HALT: stateNext = ST_HALT;
            default: stateNext = ST_IF;
        endcase
    end

    ctrl_decode uDecode (
        .state     (stateQ),
        .opcode    (opcode),
        .zero      (zero),
        .sign      (sign),
        .PCWre     (dPCWre),
        .IRWre     (dIRWre),
        .InsMemRW  (dInsMemRW),
        .ALUSrcA   (dALUSrcA),
        .ALUSrcB   (dALUSrcB),
        .ExtSel    (dExtSel),
        .ALUOp     (dALUOp),
        .mRD       (dmRD),
        .mWR       (dmWR),
        .RegWre    (dRegWre),
        .RegDst    (dRegDst),
        .WrRegDSrc (dWrRegDSrc),
        .DBDataSrc (dDBDataSrc),
        .PCSrc     (dPCSrc)
    );

    // While RST is held low no control line may assert, not even the IF fetch enables.
    assign state     = stateQ;
    assign PCWre     = RST & dPCWre;
    assign IRWre     = RST & dIRWre;
    assign InsMemRW  = RST & dInsMemRW;
    assign ALUSrcA   = RST & dALUSrcA;
    assign ALUSrcB   = RST & dALUSrcB;
    assign ExtSel    = RST & dExtSel;
    assign ALUOp     = RST ? dALUOp : 3'b000;
    assign mRD       = RST & dmRD;
    assign mWR       = RST & dmWR;
    assign RegWre    = RST & dRegWre;
    assign RegDst    = RST ? dRegDst : 2'b00;
    assign WrRegDSrc = RST & dWrRegDSrc;
    assign DBDataSrc = RST & dDBDataSrc;
    assign PCSrc     = RST ? dPCSrc : 2'b00;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: vector table, hand sequences, random instruction stream.
// Latency: n/a.
// Backpressure: n/a. Build with CTRL_HALT_EN defined to exercise the HALT state.
module tb_multi_cycle_ctrl;

    // Encodings written out locally so a wrong package value shows up as a difference.
    localparam logic [2:0] P_IF = 3'b000, P_ID = 3'b001, P_EXA = 3'b110, P_EXB = 3'b101;
    localparam logic [2:0] P_EXL = 3'b010, P_MEM = 3'b100, P_WB = 3'b011, P_HALT = 3'b111;

    localparam logic [2:0] C_NOP = 3'd0, C_ALU = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3;
    localparam logic [2:0] C_BR = 3'd4, C_JUMP = 3'd5, C_HALT = 3'd6;

    typedef struct packed {
        logic       PCWre;
        logic       IRWre;
        logic       InsMemRW;
        logic       ALUSrcA;
        logic       ALUSrcB;
        logic       ExtSel;
        logic [2:0] ALUOp;
        logic       mRD;
        logic       mWR;
        logic       RegWre;
        logic [1:0] RegDst;
        logic       WrRegDSrc;
        logic       DBDataSrc;
        logic [1:0] PCSrc;
    } outT;

    typedef struct packed {
        logic [2:0] cls;
        logic [1:0] dst;
        logic       a;
        logic       b;
        logic       ext;
        logic [2:0] alu;
    } infoT;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        int         cycles;
        logic [1:0] pcSrcAtRetire;
        logic       wroteReg;
    } vecT;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] opcode = 6'b000000;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR, RegWre;
    logic       WrRegDSrc, DBDataSrc;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    outT        dutOut;

    int nChecks = 0;
    int nPass   = 0;

    multi_cycle_ctrl dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign), .state(state),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
        .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc)
    );

    assign dutOut = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR,
                     RegWre, RegDst, WrRegDSrc, DBDataSrc, PCSrc};

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Instruction classes and static steering, straight from the opcode table.
    function automatic infoT info(input logic [5:0] op);
        case (op)
            6'b000000: return '{C_ALU,   2'b10, 1'b0, 1'b0, 1'b0, 3'b000};
            6'b000001: return '{C_ALU,   2'b10, 1'b0, 1'b0, 1'b0, 3'b001};
            6'b000010: return '{C_ALU,   2'b01, 1'b0, 1'b1, 1'b1, 3'b000};
            6'b010000: return '{C_ALU,   2'b10, 1'b0, 1'b0, 1'b0, 3'b100};
            6'b010001: return '{C_ALU,   2'b01, 1'b0, 1'b1, 1'b0, 3'b100};
            6'b010010: return '{C_ALU,   2'b01, 1'b0, 1'b1, 1'b0, 3'b011};
            6'b010011: return '{C_ALU,   2'b01, 1'b0, 1'b1, 1'b0, 3'b111};
            6'b011000: return '{C_ALU,   2'b10, 1'b1, 1'b0, 1'b0, 3'b010};
            6'b100110: return '{C_ALU,   2'b10, 1'b0, 1'b0, 1'b0, 3'b110};
            6'b100111: return '{C_ALU,   2'b01, 1'b0, 1'b1, 1'b1, 3'b110};
            6'b110000: return '{C_STORE, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000};
            6'b110001: return '{C_LOAD,  2'b01, 1'b0, 1'b1, 1'b1, 3'b000};
            6'b110100, 6'b110101, 6'b110110:
                       return '{C_BR,    2'b00, 1'b0, 1'b0, 1'b1, 3'b001};
            6'b111000, 6'b111001, 6'b111010:
                       return '{C_JUMP,  2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
            6'b111111: return '{C_HALT,  2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
            default:   return '{C_NOP,   2'b00, 1'b0, 1'b0, 1'b0, 3'b000};
        endcase
    endfunction

    // Phases an instruction walks through, derived from the per-class cycle counts.
    function automatic int seqLen(input logic [5:0] op);
        case (info(op).cls)
            C_JUMP:  return 2;
            C_BR:    return 3;
            C_LOAD:  return 5;
`ifdef CTRL_HALT_EN
            C_HALT:  return 3;
`else
            C_HALT:  return 2;
`endif
            default: return 4;
        endcase
    endfunction

    function automatic logic [2:0] phaseAt(input logic [5:0] op, input int i);
        logic [2:0] seq [5];
        case (info(op).cls)
            C_JUMP:  seq = '{P_IF, P_ID, P_IF, P_IF, P_IF};
            C_BR:    seq = '{P_IF, P_ID, P_EXB, P_IF, P_IF};
            C_STORE: seq = '{P_IF, P_ID, P_EXL, P_MEM, P_IF};
            C_LOAD:  seq = '{P_IF, P_ID, P_EXL, P_MEM, P_WB};
            C_HALT:  seq = '{P_IF, P_ID, P_HALT, P_HALT, P_HALT};
            default: seq = '{P_IF, P_ID, P_EXA, P_WB, P_IF};
        endcase
        return seq[i];
    endfunction

    // Reference outputs: the PC is written exactly once, in the last phase of the instruction.
    function automatic outT expOut(input logic [5:0] op, input logic z, input logic s,
                                   input logic [2:0] ph, input logic last);
        outT  o;
        infoT inf;
        o = '0;
        if (ph == P_HALT) return o;
        inf = info(op);
        o.IRWre     = (ph == P_IF);
        o.InsMemRW  = (ph == P_IF);
        o.PCWre     = last;
        o.ALUSrcA   = inf.a;
        o.ALUSrcB   = inf.b;
        o.ExtSel    = inf.ext;
        o.ALUOp     = inf.alu;
        o.RegDst    = inf.dst;
        o.WrRegDSrc = (op != 6'b111010);
        o.DBDataSrc = (inf.cls == C_LOAD);
        o.mRD       = (ph == P_MEM) && (inf.cls == C_LOAD);
        o.mWR       = (ph == P_MEM) && (inf.cls == C_STORE);
        o.RegWre    = ((ph == P_WB) && (inf.cls == C_ALU || inf.cls == C_LOAD)) ||
                      ((ph == P_ID) && (op == 6'b111010));
        if (op == 6'b111001) o.PCSrc = 2'b10;
        else if (op == 6'b111000 || op == 6'b111010) o.PCSrc = 2'b11;
        else if (ph == P_EXB && ((op == 6'b110100 && z) || (op == 6'b110101 && !z) ||
                                 (op == 6'b110110 && s))) o.PCSrc = 2'b01;
        return o;
    endfunction

    // Called in IF, just after a negedge; returns in the following IF.
    task automatic runInstr(input logic [5:0] op, input logic z, input logic s);
        int n;
        n = seqLen(op);
        opcode = op; zero = z; sign = s;
        #1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("state op=%b ph%0d", op, i), state, phaseAt(op, i));
            chk($sformatf("outs op=%b ph%0d", op, i), dutOut, expOut(op, z, s, phaseAt(op, i), i == n - 1));
            @(negedge CLK); #1;
        end
    endtask

    // Counts cycles until the machine is back in IF, noting retire-time PCSrc and any reg write.
    task automatic measure(input vecT v, output int cyc, output logic [1:0] pcs, output logic rw);
        logic done;
        opcode = v.op; zero = v.z; sign = v.s;
        cyc = 0; pcs = 2'b00; rw = 1'b0; done = 1'b0;
        #1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (PCWre) pcs = PCSrc;
            if (RegWre) rw = 1'b1;
            cyc++;
            @(negedge CLK); #1;
            if (state == P_IF) done = 1'b1;
        end
        if (!done) chk($sformatf("timeout op=%b", v.op), 32'd0, 32'd1);
    endtask

    vecT        vecs[$];
    int         cyc;
    logic [1:0] pcs;
    logic       rw;
    logic [5:0] rop;

    initial begin
        vecs = '{
            '{6'b000000, 1'b0, 1'b0, 4, 2'b00, 1'b1},  // add
            '{6'b000001, 1'b1, 1'b1, 4, 2'b00, 1'b1},  // sub
            '{6'b000010, 1'b0, 1'b0, 4, 2'b00, 1'b1},  // addiu
            '{6'b011000, 1'b0, 1'b0, 4, 2'b00, 1'b1},  // sll
            '{6'b001111, 1'b0, 1'b0, 4, 2'b00, 1'b0},  // undefined -> no-op
            '{6'b110000, 1'b0, 1'b0, 4, 2'b00, 1'b0},  // sw
            '{6'b110001, 1'b0, 1'b0, 5, 2'b00, 1'b1},  // lw
            '{6'b110100, 1'b1, 1'b0, 3, 2'b01, 1'b0},  // beq taken
            '{6'b110100, 1'b0, 1'b1, 3, 2'b00, 1'b0},  // beq not taken
            '{6'b110101, 1'b0, 1'b0, 3, 2'b01, 1'b0},  // bne taken
            '{6'b110101, 1'b1, 1'b0, 3, 2'b00, 1'b0},  // bne not taken
            '{6'b110110, 1'b0, 1'b1, 3, 2'b01, 1'b0},  // bltz taken
            '{6'b110110, 1'b1, 1'b0, 3, 2'b00, 1'b0},  // bltz not taken
            '{6'b111000, 1'b0, 1'b0, 2, 2'b11, 1'b0},  // j
            '{6'b111001, 1'b0, 1'b0, 2, 2'b10, 1'b0},  // jr
            '{6'b111010, 1'b0, 1'b0, 2, 2'b11, 1'b1}   // jal
        };
`ifndef CTRL_HALT_EN
        vecs.push_back('{6'b111111, 1'b0, 1'b0, 2, 2'b00, 1'b0});  // halt as no-op
`endif

        // Reset held for 3 cycles: IF, all outputs low.
        opcode = 6'b000000;
        repeat (3) @(negedge CLK);
        #1;
        chk("reset state", state, P_IF);
        chk("reset outs", dutOut, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("release state", state, P_IF);
        chk("release IRWre/InsMemRW", {IRWre, InsMemRW}, 2'b11);

        // Vector table.
        foreach (vecs[i]) begin
            measure(vecs[i], cyc, pcs, rw);
            chk($sformatf("cycles op=%b", vecs[i].op), cyc, vecs[i].cycles);
            chk($sformatf("retire PCSrc op=%b", vecs[i].op), pcs, vecs[i].pcSrcAtRetire);
            chk($sformatf("RegWre op=%b", vecs[i].op), rw, vecs[i].wroteReg);
        end

        // add: phase trace and WB controls.
        opcode = 6'b000000; #1;
        chk("add IF", state, P_IF);
        @(negedge CLK); #1; chk("add ID", state, P_ID);
        @(negedge CLK); #1; chk("add EXA", state, P_EXA);
        @(negedge CLK); #1; chk("add WB", state, P_WB);
        chk("add WB ctl", {RegWre, RegDst, DBDataSrc, PCWre, PCSrc}, {1'b1, 2'b10, 1'b0, 1'b1, 2'b00});
        @(negedge CLK); #1; chk("add back IF", state, P_IF);

        // lw: MEM and WB controls.
        opcode = 6'b110001;
        @(negedge CLK); @(negedge CLK); #1; chk("lw EXL", state, P_EXL);
        @(negedge CLK); #1; chk("lw MEM", state, P_MEM);
        chk("lw MEM ctl", {mRD, mWR, ALUSrcB, ExtSel, PCWre}, 5'b10110);
        @(negedge CLK); #1; chk("lw WB", state, P_WB);
        chk("lw WB ctl", {DBDataSrc, RegDst, RegWre}, {1'b1, 2'b01, 1'b1});
        @(negedge CLK); #1;

        // jal: link write and jump in ID.
        opcode = 6'b111010;
        @(negedge CLK); #1;
        chk("jal ID ctl", {state, RegWre, RegDst, WrRegDSrc, PCSrc, PCWre},
            {P_ID, 1'b1, 2'b00, 1'b0, 2'b11, 1'b1});
        @(negedge CLK); #1; chk("jal back IF", state, P_IF);

        // Reset mid-instruction: asynchronous return to IF with no enable pulse.
        opcode = 6'b110001;
        @(negedge CLK); @(negedge CLK); #1;
        chk("abort EXL", state, P_EXL);
        #2 RST = 1'b0;
        #1;
        chk("abort state", state, P_IF);
        chk("abort outs", dutOut, 32'd0);
        @(posedge CLK); #1;
        chk("abort hold outs", dutOut, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("abort release IRWre", {state, IRWre}, {P_IF, 1'b1});

        // Random instruction stream against the reference model.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
            else begin
                case ($urandom_range(0, 17))
                    0: rop = 6'b000000;  1: rop = 6'b000001;  2: rop = 6'b000010;
                    3: rop = 6'b010000;  4: rop = 6'b010001;  5: rop = 6'b010010;
                    6: rop = 6'b010011;  7: rop = 6'b011000;  8: rop = 6'b100110;
                    9: rop = 6'b100111; 10: rop = 6'b110000; 11: rop = 6'b110001;
                   12: rop = 6'b110100; 13: rop = 6'b110101; 14: rop = 6'b110110;
                   15: rop = 6'b111000; 16: rop = 6'b111001; default: rop = 6'b111010;
                endcase
            end
            if (rop == 6'b111111) rop = 6'b000000;
            runInstr(rop, 1'($urandom), 1'($urandom));
        end

        // halt last, since with HALT enabled only reset leaves it.
`ifdef CTRL_HALT_EN
        runInstr(6'b111111, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("halt hold state c%0d", k), state, P_HALT);
            chk($sformatf("halt hold outs c%0d", k), dutOut, 32'd0);
            @(negedge CLK); #1;
        end
        RST = 1'b0; #1;
        chk("halt reset state", state, P_IF);
`else
        runInstr(6'b111111, 1'b1, 1'b1);
        chk("halt no-op back IF", state, P_IF);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Control unit for the multi-cycle CPU. It holds the instruction-phase state machine and decodes the latched opcode into every datapath control line. It sits directly upstream of the register file, ALU, PC and memories. The register file consumes `state`, `RegWre`, `RegDst`, `DBDataSrc` and `WrRegDSrc` from this block and relies on `state` encodings ID=3'b001 and WB=3'b011.

## Interface
Parameters: none; all encodings are fixed in the package.

Ports:
- CLK  in  1  clock; state register updates on posedge.
- RST  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26], stable from ID onward.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- state  out  3  current phase.
- PCWre  out  1  PC load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- ALUOp  out  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 unsigned lt, 110 signed lt, 111 xor.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- RegWre  out  1  register write enable.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  0 = PC+4, 1 = DB bus.
- DBDataSrc  out  1  0 = ALU, 1 = RAM.
- PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target.

## Operation
State encodings:
- IF 000, ID 001, EXA 110, EXB 101, EXL 010, MEM 100, WB 011, HALT 111.

Transitions:
- IF->ID always.
- ID->IF for j/jal/jr.
- ID->EXB for beq/bne/bltz.
- ID->EXL for sw/lw.
- ID->HALT for halt (see Configuration).
- ID->EXA otherwise.
- EXA->WB.
- EXB->IF.
- EXL->MEM.
- MEM->IF for sw; MEM->WB for lw.
- WB->IF.
- HALT->HALT.

Opcodes:
- add 000000, sub 000001, addiu 000010.
- and 010000, andi 010001, ori 010010, xori 010011.
- sll 011000, slt 100110, slti 100111.
- sw 110000, lw 110001.
- beq 110100, bne 110101, bltz 110110.
- j 111000, jr 111001, jal 111010, halt 111111.
- Any other opcode follows the EXA path with RegWre=0 (no-op).

Outputs are combinational from (state, opcode, zero, sign):
- IRWre=1 and InsMemRW=1 in IF only.
- PCWre=1 only in an instruction's final state: ID for j/jal/jr, EXB, MEM for sw, WB.
- RegWre=1 in WB for ALU ops and lw. It is also 1 in ID for jal, with RegDst=00 and WrRegDSrc=0.
- RegDst=10 for R-type, 01 for I-type and lw.
- DBDataSrc=1 only for lw. WrRegDSrc=1 except jal.
- ALUSrcA=1 only for sll.
- ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
- ExtSel=1 for addiu, slti, lw, sw, branches; 0 for logical immediates.
- mRD=1 in MEM for lw. mWR=1 in MEM for sw. Both are 0 in every other state.
- PCSrc:
  - 01 when beq && zero, bne && !zero, or bltz && sign.
  - 10 for jr.
  - 11 for j/jal.
  - 00 otherwise.

## Timing
- State changes on posedge CLK. Outputs settle within the same cycle, so the register file's negedge write sees stable controls.
- Cycle counts: j/jr/jal 2; branch 3; sw 4; ALU 4; lw 5.
- RST low: state=000 immediately, asynchronously. All outputs are forced to 0 while RST=0, including IRWre and InsMemRW. After RST rises, the first posedge begins an IF with IRWre=1.
- Reset mid-instruction abandons it. No PCWre or RegWre pulse is issued.
- zero and sign are sampled only in EXB. Their value in any other state is ignored.

## Configuration
- CTRL_HALT_EN defined: halt moves ID->HALT with PCWre=0. HALT holds all outputs 0 except state=111 until RST.
- CTRL_HALT_EN undefined: halt is a no-op. It goes ID->IF with PCWre=1 and PCSrc=00, and HALT is unreachable.

## Structure
- Package ctrl_pkg holds the state, opcode and ALUOp localparams.
- Sub-module ctrl_decode: purely combinational (state, opcode, flags) -> outputs.
- The top level keeps only the state register and next-state logic.

## Test plan
- Reset low for 3 cycles -> state=000 and all outputs 0. On release, IF has IRWre=1 and InsMemRW=1.
- add: states 000->001->110->011->000. In WB: RegWre=1, RegDst=10, DBDataSrc=0, PCWre=1 with PCSrc=00.
- lw: 000->001->010->100->011. In MEM: mRD=1, ALUSrcB=1, ExtSel=1. In WB: DBDataSrc=1, RegDst=01.
- beq with zero=1 -> in EXB, PCSrc=01 and PCWre=1. With zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- jal -> 2 cycles. In ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- halt with CTRL_HALT_EN -> state sticks at 111 for 10 cycles with PCWre=0. Without the macro -> back to 000 after 2 cycles.
